// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 32-bit ALU among NUM_REQ requesters.
// Optional per-requester saturating grant counters under `ALU_ARB_STATS_EN.

`ifdef ALU_ARB_STATS_EN
module alu_arb_grant_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk) begin
    if (rst)                            count <= '0;
    else if (inc && count != 16'hFFFF)  count <= count + 16'd1;
  end
endmodule
`endif

module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  input  logic [NUM_REQ-1:0][3:0]  req_ctrl,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_control,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              rsp_result,
  output logic                     rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, win_id, nxt_ptr, id_q;
  logic            found, accept_win, hs;

  // Scan upward from ptr, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        win_id = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // rst gating keeps req_ready low for the whole reset window.
  assign accept_win = !rst && (state_q == IDLE || (state_q == RESP && rsp_ready));
  assign hs         = accept_win && found;
  assign req_ready  = hs ? (NUM_REQ'(1) << win_id) : '0;
  assign nxt_ptr    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = hs ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        ptr_q       <= nxt_ptr;
        id_q        <= win_id;
        alu_a       <= req_a[win_id];
        alu_b       <= req_b[win_id];
        alu_control <= req_ctrl[win_id];
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ctr
    alu_arb_grant_ctr u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (req_ready[i]),
      .count (grant_count[i])
    );
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter against an operation-level model.
// Stats checks run only when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N-1:0][31:0] req_a = '0;
  logic [N-1:0][31:0] req_b = '0;
  logic [N-1:0][3:0]  req_ctrl = '0;
  logic [31:0]        alu_a, alu_b, alu_result;
  logic [3:0]         alu_control;
  logic               alu_zero;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [W-1:0]       rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_zero;
`ifdef ALU_ARB_STATS_EN
  logic [N-1:0][15:0] grant_count;
`endif

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {31'b0, $signed(a) < $signed(b)};
      default: return ~(a | b);
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == 32'd0);

  // Operation-level model: at most one op in the ALU slot, at most one response held.
  int          m_ptr = 0;
  bit          m_exec = 0, m_rsp = 0;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_c;
  int          m_id = 0, m_rsp_id = 0;
  bit          m_zero;
  int          last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i]    = $urandom;
      req_b[i]    = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
      req_ctrl[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_ctrl", 32'(alu_control), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_zero", 32'(rsp_zero), 0);
    end
    m_ptr = 0; m_exec = 0; m_rsp = 0;
    rst = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] v, input bit rr);
    logic [N-1:0] exp_ready;
    @(negedge clk);
    req_valid = v; rsp_ready = rr;
    #1;
    last_w = -1;
    if (!m_exec && (!m_rsp || rr))
      for (int k = 0; k < N; k++)
        if (last_w < 0 && v[(m_ptr + k) % N]) last_w = (m_ptr + k) % N;
    exp_ready = (last_w >= 0) ? N'(1) << last_w : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      chk("rsp_id", 32'(rsp_id), m_rsp_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
    end
    if (m_exec) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_control", 32'(alu_control), 32'(m_c));
    end
    if (m_exec) begin
      m_res = alu_f(m_a, m_b, m_c); m_zero = (m_res == 0);
      m_rsp_id = m_id; m_rsp = 1; m_exec = 0;
    end else if (m_rsp && rr) begin
      m_rsp = 0;
    end
    if (last_w >= 0) begin
      m_a = req_a[last_w]; m_b = req_b[last_w]; m_c = req_ctrl[last_w];
      m_id = last_w; m_exec = 1; m_ptr = (last_w + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] snap_res;
  logic [W-1:0] snap_id;
  logic snap_zero;

  initial begin
    rand_ops();
    do_reset(2);
    step('1, 1'b1);
    chk("first_grant", last_w, 0);
    repeat (3) step('0, 1'b1);

    // single op: requester 2, 5 - 7
    req_a[2] = 32'd5; req_b[2] = 32'd7; req_ctrl[2] = 4'b0001;
    step(4'b0100, 1'b1);
    chk("single_grant", last_w, 2);
    step('0, 1'b1);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_result", rsp_result, 32'hFFFFFFFE);
    chk("single_zero", 32'(rsp_zero), 0);
    chk("single_id", 32'(rsp_id), 2);
    step('0, 1'b1);

    // round robin from a fresh pointer
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      step('1, 1'b1);
      if (i % 2 == 0) chk("rr_order", last_w, (i / 2) % N);
    end
    repeat (2) step('0, 1'b1);

    // backpressure
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    snap_res = rsp_result; snap_id = rsp_id; snap_zero = rsp_zero;
    for (int i = 0; i < 5; i++) begin
      step('1, 1'b0);
      chk("bp_result_stable", rsp_result, snap_res);
      chk("bp_id_stable", 32'(rsp_id), 32'(snap_id));
      chk("bp_zero_stable", 32'(rsp_zero), 32'(snap_zero));
    end
    step('1, 1'b1);
    chk("bp_release_grant", last_w, 2);
    repeat (3) step('0, 1'b1);

    // zero flag
    req_a[1] = 32'h1234; req_b[1] = 32'h1234; req_ctrl[1] = 4'b0001;
    step(4'b0010, 1'b1);
    step('0, 1'b1);
    chk("zero_result", rsp_result, 0);
    chk("zero_flag", 32'(rsp_zero), 1);
    chk("zero_id", 32'(rsp_id), 1);
    step('0, 1'b1);

    // reset while in EXEC
    step('1, 1'b1);
    do_reset(1);
    step('0, 1'b1);
    step('0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      step(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

`ifdef ALU_ARB_STATS_EN
    do_reset(1);
    @(negedge clk);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (140004) @(posedge clk);
    #1;
    chk("stats_sat", 32'(grant_count[0]), 32'hFFFF);
    chk("stats_other", 32'(grant_count[1]), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one combinational 32-bit ALU among `NUM_REQ` requesters (for example decode, branch-compare, and address-generation units) using round-robin arbitration.
- Latches the winner's operands and ALU control code, drives them to the ALU, captures the result and zero flag, and returns them tagged with the requester ID.
- Holds the response until it is accepted.
- Sits between the requesting pipeline units and the ALU instance; the ALU stays outside this block.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: requester ID width; must satisfy 2^`ID_W` >= `NUM_REQ`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester operation request.
- `req_ready`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `req_a`  in  32*`NUM_REQ`  operand A; requester i uses slice [32i+31:32i].
- `req_b`  in  32*`NUM_REQ`  operand B, same packing as `req_a`.
- `req_ctrl`  in  4*`NUM_REQ`  4-bit ALU control code, same encoding as the ALU control input.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_control`  out  4  registered control code to the ALU.
- `alu_result`  in  32  ALU result, combinational from `alu_a`/`alu_b`/`alu_control`.
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response accepted by the consumer.
- `rsp_id`  out  `ID_W`  index of the requester that owns the response.
- `rsp_result`  out  32  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `grant_count`  out  16*`NUM_REQ`  per-requester grant counters; present only with `ALU_ARB_STATS_EN` defined.

## Operation
- **FSM states:** IDLE, EXEC, RESP. Reset state is IDLE.
- **Accept window:** the block can accept a request when it is in IDLE, or when it is in RESP with `rsp_ready`=1 in that cycle.
- **Arbitration:** the round-robin pointer `ptr` resets to 0.
  - The winner is the first requester with `req_valid`=1 when scanning upward from `ptr` and wrapping modulo `NUM_REQ`.
  - `req_ready[winner]`=1 combinationally in an accept window; all other `req_ready` bits are 0.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Handshake (`req_valid[i]` & `req_ready[i]`):**
  - Latch the requester's A, B and ctrl slices into `alu_a`, `alu_b`, `alu_control`.
  - Latch i into the ID register.
  - Set `ptr` = (i+1) mod `NUM_REQ`.
  - Go to EXEC.
- **Accept window with no valid request:**
  - From IDLE, stay in IDLE.
  - From RESP with `rsp_ready`=1, go to IDLE.
- **EXEC:** capture `alu_result` and `alu_zero` into `rsp_result` and `rsp_zero`, assert `rsp_valid`, and go to RESP. Exactly one cycle is spent in EXEC.
- **RESP:**
  - Hold `rsp_valid`=1 with `rsp_id`, `rsp_result`, and `rsp_zero` stable until `rsp_ready`=1.
  - While stalled, `req_ready` is all zero.
- **Control codes:** forwarded unmodified. Undefined codes return whatever the ALU produces for them; the arbiter does not check them.
- **Reset values:**
  - `req_ready`=0.
  - `alu_a`=0, `alu_b`=0, `alu_control`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0.
  - `ptr`=0 and FSM in IDLE.
  - `grant_count` all 0.
- **Reset mid-operation:** an in-flight operation in EXEC or RESP is dropped silently. No response is produced for it, and the first cycle after reset is IDLE.

## Timing
- **Latency:** handshake at edge N; `alu_*` valid after N; `rsp_valid`=1 after edge N+1. Request-to-response latency is 2 cycles.
- **Throughput:** with `rsp_ready` held at 1, one operation completes every 2 cycles. The response cycle of operation k coincides with the accept cycle of operation k+1.
- **Simultaneous events:** in RESP with `rsp_ready`=1 and a pending request, the response handshake and the new request handshake both complete at the same edge; `rsp_valid` drops for the EXEC cycle.
- **Fairness:** a requester holding `req_valid` continuously is granted within `NUM_REQ` grants.
- **Wrap-around:** a grant to requester `NUM_REQ`-1 sets `ptr` to 0.

## Configuration
- **`ALU_ARB_STATS_EN` defined:**
  - Adds the `grant_count` port.
  - Counter i increments by 1 on every handshake of requester i.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Counters clear only on `rst`.
- **`ALU_ARB_STATS_EN` undefined:** no counters and no `grant_count` port; all other behaviour is identical.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with all `req_valid`=1. Required: all outputs are 0 during reset. First grant after reset goes to requester 0.
- **Single op:** requester 2 sends A=5, B=7, ctrl=4'b0001 (SUB). Required: `rsp_valid` 2 cycles after the handshake, `rsp_result`=32'hFFFFFFFE, `rsp_zero`=0, `rsp_id`=2.
- **Round-robin:** hold all 4 `req_valid`=1 with `rsp_ready`=1 for 8 operations. Required: grant order 0,1,2,3,0,1,2,3 and one response every 2 cycles.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with a response pending, then set it to 1.
  - Required: `rsp_*` stable throughout the stall and `req_ready`=0 throughout.
  - On release, the next request is accepted in the same cycle as the response handshake.
- **Zero flag:** requester 1 sends A=B=32'h1234, ctrl=SUB. Required: `rsp_result`=0, `rsp_zero`=1.
- **Reset mid-op, and stats with `ALU_ARB_STATS_EN` defined:**
  - Assert `rst` in EXEC. Required: no response, and IDLE on the next cycle.
  - Make 70000 grants to requester 0. Required: `grant_count[15:0]`=16'hFFFF.
